// File: rtl/xram_dma.sv
// xram_dma: block DMA between the shared RAM data port and word streams (XRAM_DMA_IRQ_EN adds the done interrupt)
module xram_dma #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   input  logic              ctrl_data_sel,
   output logic              dma_sel,
   output logic              dma_we,
   output logic [ADDR_W-2:0] dma_addr,
   output logic [DATA_W-1:0] dma_data_in,
   input  logic [DATA_W-1:0] dma_data_out,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
`ifdef XRAM_DMA_IRQ_EN
   ,
   output logic              irq
`endif
);
   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-2:0] base_q, base_d, cur_q, cur_d;
   logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d, iss_q, iss_d;
   logic done_q, done_d, pend_q;
   logic [DATA_W-1:0] fifo_q [2];
   logic rptr_q, wptr_q;
   logic [1:0] cnt_q;
   logic reg_wr, start, abort, busy, wr_xfer, rd_issue, push, pop, flush, irq_bit, unused_data;
   logic [DATA_W-1:0] status;
   assign unused_data = ^data_in;
   assign reg_wr   = sel && we;
   assign start    = reg_wr && addr == 2'd2 && data_in[0];
   assign abort    = reg_wr && addr == 2'd2 && data_in[2];
   assign busy     = state_q != IDLE;
   assign flush    = abort && busy;
   assign in_ready = state_q == WRITE && !ctrl_data_sel;
   assign wr_xfer  = in_valid && in_ready;
   // occupancy plus the in-flight read is capped at the FIFO depth
   assign rd_issue = state_q == READ && !ctrl_data_sel && (cnt_q + {1'b0, pend_q}) < 2'd2;
   assign push     = pend_q && !flush;
   assign pop      = out_valid && out_ready;
   assign dma_sel     = wr_xfer || rd_issue;
   assign dma_we      = wr_xfer;
   assign dma_addr    = dma_sel ? cur_q : '0;
   assign dma_data_in = wr_xfer ? in_data : '0;
   assign out_valid   = cnt_q != 2'd0;
   assign out_data    = fifo_q[rptr_q];
`ifdef XRAM_DMA_IRQ_EN
   assign irq     = done_q;
   assign irq_bit = done_q;
`else
   assign irq_bit = 1'b0;
`endif
   // STATUS word assembly
   always_comb begin
      status = '0;
      status[0] = busy;
      status[1] = done_q;
      status[LEN_W+1:2] = rem_q;
      status[DATA_W-1] = irq_bit;
   end
   assign data_out = addr == 2'd0 ? DATA_W'(base_q) : addr == 2'd1 ? DATA_W'(len_q) : addr == 2'd3 ? status : '0;
   // next-state and register-window updates
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
      iss_d   = iss_q;
      done_d  = done_q;
      if (reg_wr && !busy && addr == 2'd0) base_d = data_in[ADDR_W-2:0];
      if (reg_wr && !busy && addr == 2'd1) len_d = data_in[LEN_W-1:0];
      if (reg_wr && addr == 2'd3) done_d = 1'b0;
      if (dma_sel) cur_d = cur_q + (ADDR_W-1)'(1);
      if (wr_xfer || pop) rem_d = rem_q - LEN_W'(1);
      if (rd_issue) iss_d = iss_q + LEN_W'(1);
      case (state_q)
         IDLE: if (start) begin
            done_d  = 1'b0;
            cur_d   = base_q;
            rem_d   = len_q;
            iss_d   = '0;
            state_d = len_q == '0 ? DONE : data_in[1] ? READ : WRITE;
         end
         WRITE: if (wr_xfer && rem_q == LEN_W'(1)) state_d = DONE;
         READ: if (rd_issue && iss_q + LEN_W'(1) == len_q) state_d = DRAIN;
         DRAIN: if (cnt_q == 2'd0 && !pend_q) state_d = DONE;
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         done_d  = done_q;
      end
   end
   // control state registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         len_q   <= '0;
         cur_q   <= '0;
         rem_q   <= '0;
         iss_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
         iss_q   <= iss_d;
         done_q  <= done_d;
      end
   // read-return capture and two-entry output FIFO; abort drops both
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         rptr_q    <= 1'b0;
         wptr_q    <= 1'b0;
         cnt_q     <= 2'd0;
         pend_q    <= 1'b0;
      end else begin
         pend_q <= rd_issue && !flush;
         if (flush) begin
            rptr_q <= 1'b0;
            wptr_q <= 1'b0;
            cnt_q  <= 2'd0;
         end else begin
            if (push) begin
               fifo_q[wptr_q] <= dma_data_out;
               wptr_q <= !wptr_q;
            end
            if (pop) rptr_q <= !rptr_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
         end
      end
endmodule

// File: tb/tb_xram_dma.sv
// tb_xram_dma: randomized stream/RAM transfers against a word-level memory model
module tb_xram_dma;
   logic clk = 1'b0, rst_n;
   logic sel, we, ctrl_data_sel, in_valid, out_ready;
   logic [1:0] addr;
   logic [31:0] data_in, data_out, dma_data_in, dma_data_out, in_data, out_data;
   logic dma_sel, dma_we, in_ready, out_valid;
   logic [11:0] dma_addr;
`ifdef XRAM_DMA_IRQ_EN
   logic irq;
`endif
   logic [31:0] ram [4096];
   logic [31:0] mdl [4096];
   logic [31:0] rd_q;
   int n_chk = 0, n_err = 0;

   xram_dma dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .addr(addr), .data_in(data_in), .data_out(data_out),
      .ctrl_data_sel(ctrl_data_sel), .dma_sel(dma_sel), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_data_in(dma_data_in), .dma_data_out(dma_data_out), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef XRAM_DMA_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   // RAM data port: writes land on the edge, reads return one cycle later
   always @(posedge clk)
      if (dma_sel) begin
         if (dma_we) ram[dma_addr] <= dma_data_in;
         else rd_q <= ram[dma_addr];
      end
   assign dma_data_out = rd_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; data_in = d;
      @(posedge clk); #1;
      sel = 1'b0; we = 1'b0; data_in = '0;
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1 d = data_out;
   endtask

   // one programmed transfer; pat 0 = always ready/valid, 1 = toggling ready, 2 = random
   task automatic xfer(input bit dir, input logic [11:0] b, input int n, input int pat, input int cpct,
                       input logic [31:0] cmask, output int dcyc, output int fov, output int stall);
      int acc, pops, iss;
      bit fin;
      logic [31:0] st;
      logic [31:0] src[$];
      logic [31:0] rx[$];
      acc = 0; pops = 0; iss = 0; fin = 0; dcyc = -1; fov = -1; stall = 0; st = '0;
      for (int i = 0; i < n; i++) src.push_back($urandom);
      ctrl_data_sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      reg_wr(2'd0, 32'(b));
      reg_wr(2'd1, 32'(n));
      reg_wr(2'd2, {29'd0, 1'b0, dir, 1'b1});
      addr = 2'd3;
      for (int k = 1; k < 400 && !fin; k++) begin
         ctrl_data_sel = (k < 32 && cmask[k]) || ($urandom_range(99) < cpct);
         in_valid = !dir && acc < n && (pat == 0 || $urandom_range(1) == 1);
         in_data = acc < n ? src[acc] : '0;
         out_ready = pat == 0 ? 1'b1 : pat == 1 ? k[0] : 1'($urandom_range(1));
         @(negedge clk);
         st = data_out;
         if (!st[0]) begin fin = 1; dcyc = k - 1; end
         if (ctrl_data_sel) chk("ctrl_wins", 32'(dma_sel), 0);
         chk("no_stray_wr", 32'(dma_we), 32'(in_valid && in_ready));
         if (!dir) chk("in_ready", 32'(in_ready), 32'(acc < n && !ctrl_data_sel));
         if (!dir && acc < n && !in_ready) stall++;
         if (in_valid && in_ready) begin
            chk("wr_addr", 32'(dma_addr), (b + acc) % 4096);
            chk("wr_data", dma_data_in, src[acc]);
            mdl[(b + acc) % 4096] = src[acc];
            acc++;
         end
         if (dma_sel && !dma_we) begin
            chk("rd_addr", 32'(dma_addr), (b + iss) % 4096);
            iss++;
         end
         if (out_valid && fov < 0) fov = k - 1;
         if (out_valid && out_ready) begin
            rx.push_back(out_data);
            pops++;
         end
         if (dir) chk("outstanding_le2", 32'((iss - pops) <= 2), 1);
         @(posedge clk); #1;
      end
      ctrl_data_sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("finished", 32'(fin), 1);
      chk("done_bit", 32'(st[1]), 1);
      chk("rem_zero", 32'(st[13:2]), 0);
      if (dir) begin
         chk("n_issued", iss, n);
         chk("n_popped", pops, n);
         for (int i = 0; i < n && i < pops; i++) chk("rd_data", rx[i], mdl[(b + i) % 4096]);
      end else begin
         chk("n_written", acc, n);
         chk("no_reads", iss, 0);
         for (int i = 0; i < n; i++) chk("ram", ram[(b + i) % 4096], src[i]);
      end
   endtask

   initial begin
      int dc, fo, sl, pops;
      logic [31:0] d;
      logic [11:0] b;
      int n;
      rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd3; data_in = '0;
      ctrl_data_sel = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_status", data_out, 0);
      chk("rst_dma_sel", 32'(dma_sel), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      reg_wr(2'd0, 32'hFFFF_FFFF);
      reg_rd(2'd0, d); chk("base_mask", d, 32'hFFF);
      reg_wr(2'd1, 32'h0000_1234);
      reg_rd(2'd1, d); chk("len_mask", d, 32'h234);
      reg_rd(2'd2, d); chk("ctrl_reads_0", d, 0);
      xfer(1'b0, 12'h010, 4, 0, 0, 0, dc, fo, sl);
      chk("t1_done_cyc", dc, 5);
      chk("t1_stalls", sl, 0);
      reg_rd(2'd3, d);
`ifdef XRAM_DMA_IRQ_EN
      chk("irq_set", 32'(irq), 1);
      chk("st_bit31", 32'(d[31]), 1);
`else
      chk("st_bit31", 32'(d[31]), 0);
`endif
      reg_wr(2'd3, 32'h0);
      reg_rd(2'd3, d); chk("done_clr", 32'(d[1]), 0);
`ifdef XRAM_DMA_IRQ_EN
      chk("irq_clr", 32'(irq), 0);
`endif
      xfer(1'b1, 12'h010, 4, 1, 0, 0, dc, fo, sl);
      chk("t2_first_valid", fo, 2);
      xfer(1'b0, 12'h100, 6, 0, 0, 32'b11100, dc, fo, sl);
      chk("t3_stalls", sl, 3);
      chk("t3_done_cyc", dc, 10);
      xfer(1'b0, 12'hFFF, 3, 0, 0, 0, dc, fo, sl);
      chk("t4_done_cyc", dc, 4);
      xfer(1'b1, 12'hFFF, 3, 0, 0, 0, dc, fo, sl);
      chk("t4_first_valid", fo, 2);
      xfer(1'b0, 12'h020, 0, 0, 0, 0, dc, fo, sl);
      chk("t5_len0_cyc", dc, 1);
      // abort a read after three delivered words
      xfer(1'b0, 12'h200, 8, 0, 0, 0, dc, fo, sl);
      reg_wr(2'd0, 32'h200);
      reg_wr(2'd1, 32'd8);
      out_ready = 1'b1;
      reg_wr(2'd2, 32'h3);
      pops = 0;
      for (int k = 0; k < 50 && pops < 3; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            chk("ab_data", out_data, mdl[12'h200 + pops]);
            pops++;
         end
         @(posedge clk); #1;
      end
      chk("ab_popped", pops, 3);
      out_ready = 1'b0;
      reg_wr(2'd0, 32'h555);
      reg_wr(2'd2, 32'h4);
      reg_rd(2'd3, d);
      chk("ab_busy", 32'(d[0]), 0);
      chk("ab_done", 32'(d[1]), 0);
      chk("ab_rem", 32'(d[13:2]), 5);
      chk("ab_fifo_empty", 32'(out_valid), 0);
      reg_rd(2'd0, d); chk("base_locked", d, 32'h200);
      // randomized write-then-readback pairs under contention
      for (int r = 0; r < 8; r++) begin
         b = 12'($urandom);
         n = $urandom_range(1, 10);
         xfer(1'b0, b, n, 2, 30, 0, dc, fo, sl);
         xfer(1'b1, b, n, 2, 30, 0, dc, fo, sl);
      end
      // asynchronous reset mid-transfer
      reg_wr(2'd0, 32'h40);
      reg_wr(2'd1, 32'd8);
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
      reg_wr(2'd2, 32'h1);
      addr = 2'd3;
      #1 chk("pre_rst_sel", 32'(dma_sel), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dma_sel", 32'(dma_sel), 0);
      chk("arst_dma_we", 32'(dma_we), 0);
      chk("arst_dma_addr", 32'(dma_addr), 0);
      chk("arst_dma_data", dma_data_in, 0);
      chk("arst_in_ready", 32'(in_ready), 0);
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_status", data_out, 0);
`ifdef XRAM_DMA_IRQ_EN
      chk("arst_irq", 32'(irq), 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
      reg_rd(2'd1, d); chk("arst_len", d, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/xram_dma.md
# xram_dma

DMA engine that owns the shared data port of the program/data RAM when the controller is not using it. It moves a programmed block of words between the RAM and an external word stream, in either direction. It is programmed by the controller through a four-register peripheral window. The controller's own data-port accesses always take priority; the engine stalls around them without losing or duplicating words.

## Interface

Parameters:
- ADDR_W, 13: system address width; the RAM word address is ADDR_W-1 bits.
- DATA_W, 32: word width.
- LEN_W, 12: transfer length counter width.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- sel  in  1  register window select.
- we  in  1  register write enable.
- addr  in  2  register index.
- data_in  in  DATA_W  register write data.
- data_out  out  DATA_W  register read data; combinational from addr.
- ctrl_data_sel  in  1  controller is using the RAM data port this cycle.
- dma_sel  out  1  RAM data-port enable for the engine.
- dma_we  out  1  RAM write enable.
- dma_addr  out  ADDR_W-1  RAM word address.
- dma_data_in  out  DATA_W  RAM write data.
- dma_data_out  in  DATA_W  RAM read data; valid one cycle after a read.
- in_valid, in_data[DATA_W], in_ready (in, in, out): stream into RAM.
- out_valid, out_data[DATA_W], out_ready (out, out, in): stream out of RAM.
- irq  out  1  done interrupt; only present with XRAM_DMA_IRQ_EN.

## Operation

Registers:
- 0 BASE: RAM start word address, bits [ADDR_W-2:0].
- 1 LEN: word count, bits [LEN_W-1:0].
- 2 CTRL, write-only:
  - bit0 start.
  - bit1 dir: 0 = stream→RAM, 1 = RAM→stream.
  - bit2 abort.
- 3 STATUS: bit0 busy, bit1 done, bits[LEN_W+1:2] words remaining.
- Reads of index 2 return 0.
- Writes to BASE and LEN while busy are ignored.

States:
- IDLE.
  - start with LEN≠0 → WRITE (dir 0) or READ (dir 1); the current address and remaining count are loaded from BASE and LEN.
  - start with LEN=0 → DONE.
- WRITE: each accepted word is written to the current address. The address increments and the remaining count decrements. Remaining reaching 0 → DONE.
- READ: issues a read when allowed (see Timing). When the issue counter reaches LEN → DRAIN.
- DRAIN: waits until the output FIFO is empty and no read is in flight → DONE.
- DONE: sets the sticky done bit, busy=0 → IDLE next cycle.

Rules:
- busy=1 in WRITE, READ, DRAIN and DONE.
- A start while busy is ignored.
- Abort in any busy state → IDLE next cycle: FIFO flushed, in-flight read discarded, done not set.
- Done is cleared by the next accepted start, or by a write to STATUS.
- The address wraps modulo 2^(ADDR_W-1) with no error.
- Output FIFO: 2 entries. occupancy + in-flight never exceeds 2.

## Timing

Reset values:
- All outputs 0, state IDLE.
- BASE, LEN, done and the FIFO are cleared.

Data port:
- dma_sel, dma_we, dma_addr and dma_data_in are combinational from state and ctrl_data_sel.
- dma_sel=0 whenever ctrl_data_sel=1, so the controller always wins.

WRITE:
- in_ready = (state==WRITE) && !ctrl_data_sel.
- A word transfers on in_valid && in_ready; that same cycle dma_sel=dma_we=1.
- Sustained throughput is 1 word/cycle.

READ:
- A read issues (dma_sel=1, dma_we=0) when state==READ && !ctrl_data_sel && occupancy + in-flight < 2.
- The data is pushed into the FIFO on the following edge, regardless of what ctrl_data_sel does in that cycle.

Output stream:
- out_valid = FIFO non-empty; out_data = FIFO head.
- A pop happens on out_valid && out_ready.
- A push and a pop in the same cycle are allowed.
- First out_valid comes 2 cycles after the start write, with no contention.

Other:
- A start write is seen on the same edge it is written; the state changes on that edge.
- rst_n asserted mid-transfer returns the block to reset values immediately. No partial state survives, and a RAM write in progress is dropped.

## Configuration

XRAM_DMA_IRQ_EN:
- Defined:
  - irq is set when DONE is entered, and cleared by a write to STATUS or by a new start.
  - STATUS bit31 mirrors irq.
- Undefined:
  - The irq port and its logic are absent.
  - STATUS bit31 reads 0.

## Test plan

- BASE=0x10, LEN=4, dir 0, in_valid held high with data A0..A3, no contention → RAM[0x10..0x13]=A0..A3 on 4 consecutive cycles; done=1 on the 5th cycle after start; busy then 0.
- BASE=0x10, LEN=4, dir 1, out_ready toggling 1,0,1,0 → out_data A0..A3 in order with no duplicates; occupancy + in-flight never exceeds 2.
- Dir 0 transfer with ctrl_data_sel forced high for 3 cycles mid-transfer → in_ready and dma_sel low for exactly those cycles; all words still land at the correct addresses.
- BASE=2^(ADDR_W-1)-1, LEN=3, dir 0 → writes hit the top address, then 0, then 1.
- LEN=0 start → busy for 1 cycle, done=1, no dma_sel. Then a dir 1 LEN=8 transfer with abort after 3 words → IDLE next cycle, FIFO empty, done=0, remaining=5.
- With XRAM_DMA_IRQ_EN: irq rises with done and clears on a STATUS write. rst_n pulsed low mid-transfer → all outputs 0 immediately.
